// File: rtl/pulse_train_pkg.sv
// ============================================================================
// Module      : pulse_train_pkg
// Description : Shared types and defaults for the pulse train sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pulse_train_pkg;

    localparam int PT_CNT_W    = 8;
    localparam int PT_DEF_HIGH = 5;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HIGH_PH = 2'd1,
        LOW_PH  = 2'd2,
        DONE    = 2'd3
    } pt_state_t;

endpackage

`default_nettype wire

// File: rtl/pulse_phase_cnt.sv
// ============================================================================
// Module      : pulse_phase_cnt
// Description : Loadable down-counter that saturates at zero, with zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_phase_cnt
    import pulse_train_pkg::*;
#(
    parameter int WIDTH = PT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/pulse_train_ctrl.sv
// ============================================================================
// Module      : pulse_train_ctrl
// Description : Programmable pulse train sequencer (N pulses, H high, L low).
//               Optional macro PULSE_TRAIN_REPEAT_EN adds cfg_repeat_i.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_train_ctrl
    import pulse_train_pkg::*;
#(
    parameter int CNT_W    = PT_CNT_W,
    parameter int DEF_HIGH = PT_DEF_HIGH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] cfg_high_i,
    input  logic [CNT_W-1:0] cfg_low_i,
    input  logic [CNT_W-1:0] cfg_count_i,
`ifdef PULSE_TRAIN_REPEAT_EN
    input  logic             cfg_repeat_i,
`endif
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pulse_idx_o
);

    localparam logic [CNT_W-1:0] C_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_DEF_HIGH = CNT_W'(DEF_HIGH);

    pt_state_t        state_q;
    pt_state_t        state_d;

    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] low_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             busy_q;
    logic             busy_d;
    logic             done_q;
    logic             done_d;

    logic             w_accept;
    logic [CNT_W-1:0] w_high_in;
    logic [CNT_W-1:0] w_low_in;
    logic             w_repeat;
    logic             w_high_end;
    logic             w_low_end;
    logic             w_wload;
    logic [CNT_W-1:0] w_wval;
    logic             w_wen;
    logic             w_wzero;
    logic             w_pload;
    logic [CNT_W-1:0] w_pval;
    logic             w_pen;
    logic             w_pzero;

    // Zero-valued fields map to their defaults before being latched or used.
    assign w_high_in = (cfg_high_i == '0) ? C_DEF_HIGH : cfg_high_i;
    assign w_low_in  = (cfg_low_i  == '0) ? C_ONE      : cfg_low_i;
    assign w_accept  = (state_q == IDLE) && start_i && !abort_i;

`ifdef PULSE_TRAIN_REPEAT_EN
    logic repeat_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            repeat_q <= 1'b0;
        end else if (w_accept) begin
            repeat_q <= cfg_repeat_i;
        end
    end

    assign w_repeat = repeat_q;
`else
    assign w_repeat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            high_q  <= '0;
            low_q   <= '0;
            count_q <= '0;
        end else if (w_accept) begin
            high_q  <= w_high_in;
            low_q   <= w_low_in;
            count_q <= cfg_count_i;
        end
    end

    assign w_high_end = (state_q == HIGH_PH) && w_wzero;
    assign w_low_end  = (state_q == LOW_PH)  && w_wzero;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    state_d = (cfg_count_i == '0) ? DONE : HIGH_PH;
                end
            end
            HIGH_PH: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (w_high_end) begin
                    if (!w_pzero || w_repeat) begin
                        state_d = LOW_PH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            LOW_PH: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else if (w_low_end) begin
                    state_d = HIGH_PH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM: output logic (registered next cycle)
    always_comb begin
        pulse_d = (state_d == HIGH_PH);
        busy_d  = (state_d == HIGH_PH) || (state_d == LOW_PH);
        done_d  = (state_d == DONE);
        idx_d   = idx_q;
        if (w_accept) begin
            idx_d = '0;
        end else if ((state_q == LOW_PH) && (state_d == HIGH_PH)) begin
            idx_d = w_pzero ? '0 : (idx_q + C_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            idx_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            idx_q   <= idx_d;
        end
    end

    // Width counter reloads on every phase entry; values are one less than the phase length.
    assign w_wload = ((state_d == HIGH_PH) && (state_q != HIGH_PH)) ||
                     ((state_d == LOW_PH)  && (state_q != LOW_PH));
    assign w_wval  = (state_d == HIGH_PH)
                   ? (((state_q == IDLE) ? w_high_in : high_q) - C_ONE)
                   : (low_q - C_ONE);
    assign w_wen   = ((state_q == HIGH_PH) || (state_q == LOW_PH)) && !w_wload;

    // Pulse counter holds pulses remaining after the current one; it steps at LOW end,
    // and reaching LOW with it at zero can only mean a repeat wrap.
    assign w_pload = (w_accept && (cfg_count_i != '0)) ||
                     (w_low_end && w_pzero && !abort_i);
    assign w_pval  = (state_q == IDLE) ? (cfg_count_i - C_ONE) : (count_q - C_ONE);
    assign w_pen   = w_low_end && !w_pzero;

    pulse_phase_cnt #(
        .WIDTH      (CNT_W)
    ) u_width_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_wload),
        .load_val_i (w_wval),
        .en_i       (w_wen),
        .zero_o     (w_wzero)
    );

    pulse_phase_cnt #(
        .WIDTH      (CNT_W)
    ) u_pulse_cnt (
        .clk        (clk),
        .rst        (rst),
        .load_i     (w_pload),
        .load_val_i (w_pval),
        .en_i       (w_pen),
        .zero_o     (w_pzero)
    );

    assign pulse_o     = pulse_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign pulse_idx_o = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_pulse_train_ctrl.sv
// ============================================================================
// Module      : tb_pulse_train_ctrl
// Description : Scoreboard bench for pulse_train_ctrl (PULSE_TRAIN_REPEAT_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_train_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] cfg_high;
    logic [7:0] cfg_low;
    logic [7:0] cfg_count;
`ifdef PULSE_TRAIN_REPEAT_EN
    logic       cfg_repeat;
`endif
    logic       pulse;
    logic       busy;
    logic       done;
    logic [7:0] pulse_idx;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        logic       p;
        logic       b;
        logic       d;
        logic       chk_idx;
        logic [7:0] idx;
        string      tag;
    } exp_t;

    exp_t exq[$];

    pulse_train_ctrl #(
        .CNT_W       (8),
        .DEF_HIGH    (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start),
        .abort_i     (abort),
        .cfg_high_i  (cfg_high),
        .cfg_low_i   (cfg_low),
        .cfg_count_i (cfg_count),
`ifdef PULSE_TRAIN_REPEAT_EN
        .cfg_repeat_i(cfg_repeat),
`endif
        .pulse_o     (pulse),
        .busy_o      (busy),
        .done_o      (done),
        .pulse_idx_o (pulse_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int c, logic p, logic b, logic d, logic ci,
                                 logic [7:0] idx, string tag);
        exp_t e;
        e.cyc = c; e.p = p; e.b = b; e.d = d; e.chk_idx = ci; e.idx = idx; e.tag = tag;
        exq.push_back(e);
    endfunction

    // Expected one-shot train: n pulses of h cycles, l low cycles between, then done.
    function automatic int exp_train(int s, int h, int l, int n, string tag);
        int c = s + 1;
        if (n == 0) begin
            push(c, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, tag);
            c++;
        end else begin
            for (int i = 0; i < n; i++) begin
                for (int k = 0; k < h; k++) begin
                    push(c, 1'b1, 1'b1, 1'b0, 1'b1, 8'(i), tag);
                    c++;
                end
                if (i < n - 1) begin
                    for (int k = 0; k < l; k++) begin
                        push(c, 1'b0, 1'b1, 1'b0, 1'b1, 8'(i), tag);
                        c++;
                    end
                end
            end
            push(c, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0, tag);
            c++;
        end
        push(c, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, tag);
        return c;
    endfunction

    // Monitor: compares every queued expectation at the falling edge of its cycle.
    always @(negedge clk) begin
        exp_t e;
        while (exq.size() > 0 && exq[0].cyc <= cyc) begin
            e = exq.pop_front();
            checks++;
            if (e.cyc != cyc || pulse !== e.p || busy !== e.b || done !== e.d ||
                (e.chk_idx && pulse_idx !== e.idx)) begin
                errors++;
                $display("FAIL %s cyc %0d: got pulse=%b busy=%b done=%b idx=%0d, want pulse=%b busy=%b done=%b idx=%0d (slot %0d)",
                         e.tag, cyc, pulse, busy, done, pulse_idx,
                         e.p, e.b, e.d, e.idx, e.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(int c);
        while (cyc <= c) tick();
    endtask

    task automatic set_cfg(logic [7:0] h, logic [7:0] l, logic [7:0] n);
        cfg_high  = h;
        cfg_low   = l;
        cfg_count = n;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        int e;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        set_cfg(8'd0, 8'd0, 8'd0);
`ifdef PULSE_TRAIN_REPEAT_EN
        cfg_repeat = 1'b0;
`endif
        tick();
        tick();
        push(cyc, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "reset");
        tick();
        rst = 1'b1;
        tick();

        // Reset in the middle of a HIGH phase
        set_cfg(8'd5, 8'd2, 8'd3);
        start = 1'b1; s = cyc;
        push(s + 1, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "rst_mid_hi");
        push(s + 2, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "rst_mid_hi");
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        push(s + 3, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "rst_mid_clr");
        tick();
        push(s + 4, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, "rst_mid_idle");
        tick();

        // Default HIGH width: 5 high, 3 low, 5 high, done
        set_cfg(8'd0, 8'd3, 8'd2);
        start = 1'b1; e = exp_train(cyc, 5, 3, 2, "dflt");
        tick(); start = 1'b0;
        wait_until(e);

        // Empty train
        set_cfg(8'd4, 8'd4, 8'd0);
        start = 1'b1; e = exp_train(cyc, 0, 0, 0, "empty");
        tick(); start = 1'b0;
        wait_until(e);

        // cfg_low = 0 acts as 1: pattern 1,0,1
        set_cfg(8'd1, 8'd0, 8'd2);
        start = 1'b1; e = exp_train(cyc, 1, 1, 2, "low0");
        tick(); start = 1'b0;
        wait_until(e);

        // Generic train
        set_cfg(8'd2, 8'd1, 8'd3);
        start = 1'b1; e = exp_train(cyc, 2, 1, 3, "h2l1n3");
        tick(); start = 1'b0;
        wait_until(e);

        // start while busy ignored, mid-train cfg changes ignored
        set_cfg(8'd3, 8'd2, 8'd2);
        start = 1'b1; e = exp_train(cyc, 3, 2, 2, "isolate");
        tick(); start = 1'b0;
        tick();
        start = 1'b1;
        set_cfg(8'd7, 8'd9, 8'd5);
        tick(); start = 1'b0;
        wait_until(e);

        // Abort at cycle 12 of count=4, H=5, L=5
        set_cfg(8'd5, 8'd5, 8'd4);
        start = 1'b1; s = cyc;
        for (int k = 1; k <= 5; k++)  push(s + k, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "abort_hi0");
        for (int k = 6; k <= 10; k++) push(s + k, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "abort_lo0");
        for (int k = 11; k <= 12; k++) push(s + k, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, "abort_hi1");
        for (int k = 13; k <= 16; k++) push(s + k, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "abort_after");
        tick(); start = 1'b0;
        while (cyc < s + 12) tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        wait_until(s + 16);

        // start and abort together in IDLE
        set_cfg(8'd2, 8'd2, 8'd2);
        start = 1'b1; abort = 1'b1; s = cyc;
        for (int k = 1; k <= 3; k++) push(s + k, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "start_abort");
        tick(); start = 1'b0; abort = 1'b0;
        wait_until(s + 3);

        // abort during DONE does not cut the done strobe
        set_cfg(8'd2, 8'd2, 8'd0);
        start = 1'b1; e = exp_train(cyc, 0, 0, 0, "abort_done");
        tick(); start = 1'b0; abort = 1'b1;
        tick(); abort = 1'b0;
        wait_until(e);

`ifdef PULSE_TRAIN_REPEAT_EN
        // Repeat mode: 1,1,0,1,1,0,... until abort
        set_cfg(8'd2, 8'd1, 8'd2);
        cfg_repeat = 1'b1;
        start = 1'b1; s = cyc;
        for (int p = 0; p < 2; p++) begin
            push(s + 1 + 6*p, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "rep_hi0");
            push(s + 2 + 6*p, 1'b1, 1'b1, 1'b0, 1'b1, 8'd0, "rep_hi0");
            push(s + 3 + 6*p, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0, "rep_lo0");
            push(s + 4 + 6*p, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, "rep_hi1");
            push(s + 5 + 6*p, 1'b1, 1'b1, 1'b0, 1'b1, 8'd1, "rep_hi1");
            push(s + 6 + 6*p, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1, "rep_lo1");
        end
        push(s + 13, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rep_abort");
        push(s + 14, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, "rep_abort");
        tick(); start = 1'b0; cfg_repeat = 1'b0;
        while (cyc < s + 12) tick();
        abort = 1'b1;
        tick(); abort = 1'b0;
        wait_until(s + 14);
`endif

        tick();
        tick();
        if (exq.size() != 0) begin
            errors += exq.size();
            $display("FAIL scoreboard: %0d expectations never compared, want 0", exq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_train_ctrl.md
Name: pulse_train_ctrl

Overview:
- Sequencer for the 5-unit pulse generator style used in Guia_09.
- Emits a programmable train of pulses: N pulses, each HIGH for H cycles and separated by L LOW cycles.
- start/busy/done handshake to the surrounding test logic; abort stops a train early.
- Sits between a stimulus/control block and any consumer that needs timed marking pulses.

Parameters:
- CNT_W, 8, width of all config fields and internal counters.
- DEF_HIGH, 5, HIGH width used when cfg_high == 0 (the 5-unit marking).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- start  input  1  begin a train; accepted only in IDLE.
- abort  input  1  terminate the current train.
- cfg_high  input  CNT_W  HIGH cycles per pulse; 0 means DEF_HIGH.
- cfg_low  input  CNT_W  LOW cycles between pulses; 0 is treated as 1.
- cfg_count  input  CNT_W  number of pulses; 0 means an empty train.
- pulse  output  1  registered pulse output.
- busy  output  1  high in HIGH_PH and LOW_PH.
- done  output  1  one-cycle strobe on normal completion.
- pulse_idx  output  CNT_W  index of the current pulse, starting at 0.

Behaviour:
- Reset (rst == 0 at posedge): state = IDLE; pulse, busy, done, pulse_idx all 0; counters cleared. Reset overrides everything, including mid-train.
- FSM states: IDLE, HIGH_PH, LOW_PH, DONE.
- IDLE, start = 1, abort = 0:
  - Latch cfg_* into internal registers; later cfg changes are ignored until the next start.
  - cfg_count != 0 → HIGH_PH. pulse = 1 from the cycle after start is sampled (latency 1), pulse_idx = 0.
  - cfg_count == 0 → DONE directly. pulse stays 0.
- HIGH_PH: pulse = 1 for exactly H cycles (width counter).
  - At end, if pulse_idx == count-1 → DONE.
  - Otherwise → LOW_PH.
- LOW_PH: pulse = 0 for exactly L cycles, then → HIGH_PH with pulse_idx + 1.
- DONE: done = 1 for one cycle, busy = 0, then → IDLE. No trailing LOW phase after the last pulse.
- start outside IDLE is ignored; there is no queuing.
- abort in HIGH_PH or LOW_PH: next cycle pulse = 0, busy = 0, state = IDLE, done NOT asserted.
- abort and start asserted together in IDLE: abort wins, start is dropped.
- abort in DONE: done still completes its one cycle.
- Counters count down with no wrap-around. Maximum H, L and count are 2^CNT_W − 1. pulse_idx never exceeds count − 1.
- The train's total length is deterministic: count·H + (count−1)·L cycles of busy, followed by 1 done cycle.

Optional Feature:
- Macro: PULSE_TRAIN_REPEAT_EN.
- Defined: adds input port cfg_repeat (1 bit), latched on start.
  - If latched high, after the last HIGH_PH the FSM goes to LOW_PH, then restarts at pulse_idx 0 instead of going to DONE.
  - Repeats until abort. done never asserts in repeat mode.
  - count == 0 with repeat set behaves as non-repeat: DONE immediately.
- Undefined: port absent; always one-shot as described above.

Decomposition:
- Package pulse_train_pkg holds:
  - state enum (IDLE, HIGH_PH, LOW_PH, DONE);
  - CNT_W default;
  - DEF_HIGH constant.
- One natural sub-module, pulse_phase_cnt: a loadable down-counter with load/en/zero flag, instantiated twice (width counter and pulse counter).
- The FSM lives in pulse_train_ctrl.

Test Plan:
- Reset mid-train: rst = 0 during HIGH_PH with H = 5 → next posedge pulse = 0, busy = 0, state IDLE; start afterwards works normally.
- Defaults: cfg_high = 0, cfg_low = 3, cfg_count = 2, start → pulse high cycles 1–5, low 6–8, high 9–13; done at cycle 14; pulse_idx 0 then 1.
- Empty and degenerate config:
  - cfg_count = 0 → done 1 cycle after start, pulse never high.
  - cfg_low = 0, count = 2, H = 1 → pattern 1,0,1.
- Abort: count = 4, H = 5, L = 5, abort at cycle 12 → pulse = 0 and busy = 0 from cycle 13; done never asserted.
- Handshake and config isolation:
  - start while busy is ignored.
  - Changing cfg_high mid-train has no effect.
  - start + abort together in IDLE → stays IDLE.
- With PULSE_TRAIN_REPEAT_EN: cfg_repeat = 1, count = 2, H = 2, L = 1 → periodic 1,1,0,1,1,0,… with pulse_idx cycling 0/1; done never asserts; abort stops it.
